// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer driving the
// datapath write enables, with a retired-instruction counter and sticky illegal flag.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opCode,
    input  logic [5:0]       Funct,
    input  logic             dm_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             Branch,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             EXTop,
    output logic             Jump,
    output logic             writeR31,
    output logic             JumpToReg,
    output logic [2:0]       ALUop,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_ADDU = 4'd0,
        C_SUBU = 4'd1,
        C_SLL  = 4'd2,
        C_JR   = 4'd3,
        C_ORI  = 4'd4,
        C_LUI  = 4'd5,
        C_LW   = 4'd6,
        C_SW   = 4'd7,
        C_BEQ  = 4'd8,
        C_J    = 4'd9,
        C_JAL  = 4'd10,
        C_ILL  = 4'd11
    } cls_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;
    localparam logic [2:0] ALU_SLL = 3'd4;

    function automatic cls_t decode_class(input logic [5:0] op, input logic [5:0] fn);
        cls_t c;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001: c = C_ADDU;
                    6'b100011: c = C_SUBU;
                    6'b000000: c = C_SLL;
                    6'b001000: c = C_JR;
                    default:   c = C_ILL;
                endcase
            end
            6'b001101: c = C_ORI;
            6'b001111: c = C_LUI;
            6'b100011: c = C_LW;
            6'b101011: c = C_SW;
            6'b000100: c = C_BEQ;
            6'b000010: c = C_J;
            6'b000011: c = C_JAL;
            default:   c = C_ILL;
        endcase
        return c;
    endfunction

    state_t           r_state;
    state_t           w_next;
    cls_t             r_cls;
    cls_t             w_dec_cls;
    logic             r_illegal;
    logic             w_set_illegal;
    logic [CNT_W-1:0] r_retired;

    logic w_irwrite, w_pcwrite, w_regwrite, w_regdst, w_alusrc, w_branch;
    logic w_memwrite, w_memtoreg, w_extop, w_jump, w_wr31, w_jtr;
    logic [2:0] w_aluop;

    assign w_dec_cls = decode_class(opCode, Funct);

    // Next-state and control decode from the registered state and class.
    always_comb begin
        w_next        = S_FETCH;
        w_set_illegal = 1'b0;
        w_irwrite     = 1'b0;
        w_pcwrite     = 1'b0;
        w_regwrite    = 1'b0;
        w_regdst      = 1'b0;
        w_alusrc      = 1'b0;
        w_branch      = 1'b0;
        w_memwrite    = 1'b0;
        w_memtoreg    = 1'b0;
        w_extop       = 1'b0;
        w_jump        = 1'b0;
        w_wr31        = 1'b0;
        w_jtr         = 1'b0;
        w_aluop       = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                case (w_dec_cls)
                    C_J: begin
                        w_jump    = 1'b1;
                        w_pcwrite = 1'b1;
                    end
                    C_JAL: begin
                        w_jump     = 1'b1;
                        w_wr31     = 1'b1;
                        w_regwrite = 1'b1;
                        w_pcwrite  = 1'b1;
                    end
                    C_JR: begin
                        w_jtr     = 1'b1;
                        w_pcwrite = 1'b1;
                    end
                    C_ILL: begin
                        w_pcwrite     = 1'b1;
                        w_set_illegal = 1'b1;
                    end
                    default: w_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (r_cls)
                    C_ADDU: begin w_aluop = ALU_ADD; w_next = S_WB; end
                    C_SUBU: begin w_aluop = ALU_SUB; w_next = S_WB; end
                    C_SLL:  begin w_aluop = ALU_SLL; w_next = S_WB; end
                    C_ORI: begin
                        w_aluop  = ALU_OR;
                        w_alusrc = 1'b1;
                        w_extop  = 1'b1;
                        w_next   = S_WB;
                    end
                    C_LUI: begin
                        w_aluop  = ALU_LUI;
                        w_alusrc = 1'b1;
                        w_next   = S_WB;
                    end
                    C_LW, C_SW: begin
                        w_aluop  = ALU_ADD;
                        w_alusrc = 1'b1;
                        w_next   = S_MEM;
                    end
                    C_BEQ: begin
                        w_aluop   = ALU_SUB;
                        w_branch  = 1'b1;
                        w_pcwrite = 1'b1;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                case (r_cls)
                    C_SW: begin
                        // Only PCWrite follows dm_ready combinationally.
                        w_memwrite = 1'b1;
                        if (dm_ready) begin
                            w_pcwrite = 1'b1;
                            w_next    = S_FETCH;
                        end else begin
                            w_next    = S_MEM;
                        end
                    end
                    C_LW: begin
                        w_aluop  = ALU_ADD;
                        w_alusrc = 1'b1;
                        if (dm_ready) begin
                            w_next = S_WB;
                        end else begin
                            w_next = S_MEM;
                        end
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_WB: begin
                w_regwrite = 1'b1;
                w_pcwrite  = 1'b1;
                w_regdst   = (r_cls == C_ADDU) || (r_cls == C_SUBU) || (r_cls == C_SLL);
                w_memtoreg = (r_cls == C_LW);
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Gating with reset forces every control low the moment reset asserts.
    assign IRWrite   = w_irwrite  & reset;
    assign PCWrite   = w_pcwrite  & reset;
    assign RegWrite  = w_regwrite & reset;
    assign RegDst    = w_regdst   & reset;
    assign ALUSrc    = w_alusrc   & reset;
    assign Branch    = w_branch   & reset;
    assign MemWrite  = w_memwrite & reset;
    assign MemtoReg  = w_memtoreg & reset;
    assign EXTop     = w_extop    & reset;
    assign Jump      = w_jump     & reset;
    assign writeR31  = w_wr31     & reset;
    assign JumpToReg = w_jtr      & reset;
    assign ALUop     = w_aluop    & {3{reset}};
    assign state     = r_state;
    assign retired   = r_retired;
    assign illegal   = r_illegal;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Instruction class captured in DECODE for use by the later states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cls <= C_ILL;
        end else if (r_state == S_DECODE) begin
            r_cls <= w_dec_cls;
        end else begin
            r_cls <= r_cls;
        end
    end

    // Sticky illegal-encoding flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= r_illegal | w_set_illegal;
        end
    end

    // Retired-instruction counter, one count per PC update, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired <= '0;
        end else begin
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, PCWrite};
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: per-cycle state/control checks for each
// instruction class, dm_ready wait states, illegal flag, counter wrap and mid-instruction reset.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opCode;
    logic [5:0]  Funct;
    logic        dm_ready;
    logic        IRWrite, PCWrite, RegWrite, RegDst, ALUSrc, Branch;
    logic        MemWrite, MemtoReg, EXTop, Jump, writeR31, JumpToReg;
    logic [2:0]  ALUop;
    logic [2:0]  state;
    logic [31:0] retired;
    logic        illegal;
    logic [14:0] ctl;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [14:0] NONE  = 15'h0000;
    localparam logic [14:0] IRW   = 15'h4000;
    localparam logic [14:0] PCW   = 15'h2000;
    localparam logic [14:0] RGW   = 15'h1000;
    localparam logic [14:0] RDST  = 15'h0800;
    localparam logic [14:0] ASRC  = 15'h0400;
    localparam logic [14:0] BR    = 15'h0200;
    localparam logic [14:0] MW    = 15'h0100;
    localparam logic [14:0] M2R   = 15'h0080;
    localparam logic [14:0] EXT   = 15'h0040;
    localparam logic [14:0] JMP   = 15'h0020;
    localparam logic [14:0] W31   = 15'h0010;
    localparam logic [14:0] JTR   = 15'h0008;
    localparam logic [14:0] A_SUB = 15'h0001;
    localparam logic [14:0] A_OR  = 15'h0002;
    localparam logic [14:0] A_LUI = 15'h0003;
    localparam logic [14:0] A_SLL = 15'h0004;

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opCode(opCode), .Funct(Funct), .dm_ready(dm_ready),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrc(ALUSrc), .Branch(Branch), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .EXTop(EXTop), .Jump(Jump), .writeR31(writeR31), .JumpToReg(JumpToReg),
        .ALUop(ALUop), .state(state), .retired(retired), .illegal(illegal)
    );

    assign ctl = {IRWrite, PCWrite, RegWrite, RegDst, ALUSrc, Branch, MemWrite,
                  MemtoReg, EXTop, Jump, writeR31, JumpToReg, ALUop};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check state and controls in the low phase, then advance one cycle.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [14:0] c);
        #1;
        chk({tag, "_state"}, {29'd0, state}, {29'd0, st});
        chk({tag, "_ctl"}, {17'd0, ctl}, {17'd0, c});
        @(negedge clk);
    endtask

    task automatic set_ins(input logic [5:0] op, input logic [5:0] fn);
        opCode = op;
        Funct  = fn;
    endtask

    initial begin
        reset    = 1'b0;
        dm_ready = 1'b0;
        set_ins(6'b000000, 6'b100001);
        #3;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_ctl", {17'd0, ctl}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // addu: 0,1,2,4,0
        cyc("addu_f", 3'd0, IRW);
        cyc("addu_d", 3'd1, NONE);
        cyc("addu_e", 3'd2, NONE);
        cyc("addu_w", 3'd4, PCW | RGW | RDST);
        chk("addu_ret", retired, 32'd1);

        // lw with two wait cycles
        set_ins(6'b100011, 6'b000000);
        cyc("lw_f", 3'd0, IRW);
        cyc("lw_d", 3'd1, NONE);
        cyc("lw_e", 3'd2, ASRC);
        cyc("lw_m0", 3'd3, ASRC);
        cyc("lw_m1", 3'd3, ASRC);
        dm_ready = 1'b1;
        cyc("lw_m2", 3'd3, ASRC);
        dm_ready = 1'b0;
        cyc("lw_w", 3'd4, PCW | RGW | M2R);
        chk("lw_ret", retired, 32'd2);

        // sw with dm_ready high throughout (ignored outside MEM)
        set_ins(6'b101011, 6'b000000);
        dm_ready = 1'b1;
        cyc("sw_f", 3'd0, IRW);
        cyc("sw_d", 3'd1, NONE);
        cyc("sw_e", 3'd2, ASRC);
        cyc("sw_m", 3'd3, MW | PCW);
        dm_ready = 1'b0;
        chk("sw_ret", retired, 32'd3);

        set_ins(6'b000011, 6'b000000);
        cyc("jal_f", 3'd0, IRW);
        cyc("jal_d", 3'd1, JMP | W31 | RGW | PCW);
        set_ins(6'b000010, 6'b000000);
        cyc("j_f", 3'd0, IRW);
        cyc("j_d", 3'd1, JMP | PCW);
        set_ins(6'b000000, 6'b001000);
        cyc("jr_f", 3'd0, IRW);
        cyc("jr_d", 3'd1, JTR | PCW);
        chk("jmp_ret", retired, 32'd6);

        set_ins(6'b000000, 6'b100011);
        cyc("subu_f", 3'd0, IRW);
        cyc("subu_d", 3'd1, NONE);
        cyc("subu_e", 3'd2, A_SUB);
        cyc("subu_w", 3'd4, PCW | RGW | RDST);
        set_ins(6'b000000, 6'b000000);
        cyc("sll_f", 3'd0, IRW);
        cyc("sll_d", 3'd1, NONE);
        cyc("sll_e", 3'd2, A_SLL);
        cyc("sll_w", 3'd4, PCW | RGW | RDST);
        set_ins(6'b001101, 6'b000000);
        cyc("ori_f", 3'd0, IRW);
        cyc("ori_d", 3'd1, NONE);
        cyc("ori_e", 3'd2, A_OR | ASRC | EXT);
        cyc("ori_w", 3'd4, PCW | RGW);
        set_ins(6'b001111, 6'b000000);
        cyc("lui_f", 3'd0, IRW);
        cyc("lui_d", 3'd1, NONE);
        cyc("lui_e", 3'd2, A_LUI | ASRC);
        cyc("lui_w", 3'd4, PCW | RGW);
        chk("alu_ret", retired, 32'd10);

        // illegal opcode, then a normal instruction
        set_ins(6'b111111, 6'b000000);
        chk("ill_pre", {31'd0, illegal}, 32'd0);
        cyc("ill_f", 3'd0, IRW);
        cyc("ill_d", 3'd1, PCW);
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_ret", retired, 32'd11);
        set_ins(6'b000000, 6'b100001);
        cyc("post_f", 3'd0, IRW);
        cyc("post_d", 3'd1, NONE);
        cyc("post_e", 3'd2, NONE);
        cyc("post_w", 3'd4, PCW | RGW | RDST);
        chk("ill_sticky", {31'd0, illegal}, 32'd1);
        chk("post_ret", retired, 32'd12);

        // counter wrap on beq
        set_ins(6'b000100, 6'b000000);
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        chk("wrap_pre", retired, 32'hFFFF_FFFF);
        cyc("beq_f", 3'd0, IRW);
        cyc("beq_d", 3'd1, NONE);
        cyc("beq_e", 3'd2, A_SUB | BR | PCW);
        chk("wrap_ret", retired, 32'd0);
        chk("beq_next", {29'd0, state}, 32'd0);

        // reset asserted during EXEC of ori
        set_ins(6'b001101, 6'b000000);
        cyc("ori2_f", 3'd0, IRW);
        cyc("ori2_d", 3'd1, NONE);
        #1;
        chk("ori2_e_ctl", {17'd0, ctl}, {17'd0, A_OR | ASRC | EXT});
        reset = 1'b0;
        #1;
        chk("abort_ctl", {17'd0, ctl}, 32'd0);
        chk("abort_state", {29'd0, state}, 32'd0);
        chk("abort_ill", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        chk("abort_ret", retired, 32'd0);
        chk("abort_hold", {17'd0, ctl}, 32'd0);
        reset = 1'b1;
        cyc("rel_f", 3'd0, IRW);
        cyc("rel_d", 3'd1, NONE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
